// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared types and width helpers for the fetch-address generator.
//
// Contents
//   pcSrc_t          2-bit encoding of where the current fetch PC came from
//   rasCountWidth()  bits needed to hold a RAS occupancy of 0..depth
//   rasPtrWidth()    bits needed to index a RAS of the given depth
package pc_gen_pkg;

    typedef enum logic [1:0] {
        PC_SRC_SEQ = 2'd0,
        PC_SRC_BR  = 2'd1,
        PC_SRC_RET = 2'd2,
        PC_SRC_EXC = 2'd3
    } pcSrc_t;

    function automatic int rasCountWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int rasPtrWidth(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pc_generator_if.sv
// pc_generator_if: request/response bundle between the hazard/back end and the fetch-address generator.
//
// Parameters
//   WIDTH      address width in bits
//   RAS_DEPTH  return-address stack entries
// Signals (master drives i_*, slave drives o_*)
//   i_PcGen_stall        hold fetch PC
//   i_PcGen_exc_valid    exception redirect request, target in i_PcGen_exc_pc
//   i_PcGen_br_valid     resolved branch/jump redirect, target in i_PcGen_br_pc
//   i_PcGen_call         instruction at current PC is a call
//   i_PcGen_ret          instruction at current PC is a return
//   i_PcGen_flush_ras    clear the return-address stack
//   o_PcGen_pc           current fetch PC
//   o_PcGen_pc_plus      current fetch PC plus the sequential increment
//   o_PcGen_src          source of the current PC (pcSrc_t encoding)
//   o_PcGen_ras_count    valid RAS entries
//   o_PcGen_ras_empty    RAS holds no entries
//   o_PcGen_ras_full     RAS holds RAS_DEPTH entries
interface pc_generator_if
    import pc_gen_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int RAS_DEPTH = 4
);
    localparam int CW = rasCountWidth(RAS_DEPTH);

    logic             i_PcGen_stall;
    logic             i_PcGen_exc_valid;
    logic [WIDTH-1:0] i_PcGen_exc_pc;
    logic             i_PcGen_br_valid;
    logic [WIDTH-1:0] i_PcGen_br_pc;
    logic             i_PcGen_call;
    logic             i_PcGen_ret;
    logic             i_PcGen_flush_ras;
    logic [WIDTH-1:0] o_PcGen_pc;
    logic [WIDTH-1:0] o_PcGen_pc_plus;
    logic [1:0]       o_PcGen_src;
    logic [CW-1:0]    o_PcGen_ras_count;
    logic             o_PcGen_ras_empty;
    logic             o_PcGen_ras_full;

    modport master (
        output i_PcGen_stall, i_PcGen_exc_valid, i_PcGen_exc_pc,
               i_PcGen_br_valid, i_PcGen_br_pc, i_PcGen_call,
               i_PcGen_ret, i_PcGen_flush_ras,
        input  o_PcGen_pc, o_PcGen_pc_plus, o_PcGen_src,
               o_PcGen_ras_count, o_PcGen_ras_empty, o_PcGen_ras_full
    );

    modport slave (
        input  i_PcGen_stall, i_PcGen_exc_valid, i_PcGen_exc_pc,
               i_PcGen_br_valid, i_PcGen_br_pc, i_PcGen_call,
               i_PcGen_ret, i_PcGen_flush_ras,
        output o_PcGen_pc, o_PcGen_pc_plus, o_PcGen_src,
               o_PcGen_ras_count, o_PcGen_ras_empty, o_PcGen_ras_full
    );

endinterface

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack with push, pop, push+pop, flush and occupancy flags.
//
// Parameters
//   WIDTH  entry width in bits
//   DEPTH  number of entries (>= 2)
// Ports
//   clk, rst   clock and asynchronous active-high reset
//   push       write pushData as the new top
//   pop        remove the top entry (ignored when empty)
//   flush      empty the stack; wins over push/pop
//   pushData   value to push
//   topData    current top entry, read combinationally
//   count      valid entries
//   empty      count == 0
//   full       count == DEPTH
module pc_ras
    import pc_gen_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int CW    = rasCountWidth(DEPTH),
    localparam int PW    = rasPtrWidth(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] pushData,
    output logic [WIDTH-1:0] topData,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full
);

    // ptr addresses the next free slot; the top lives one slot below it.
    // When the stack is full that free slot is also the oldest entry, so a
    // push simply overwrites it.
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr;
    logic [PW-1:0]    ptrInc;
    logic [PW-1:0]    ptrDec;
    logic [CW-1:0]    cnt;
    logic             popOk;

    assign ptrInc  = (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    assign ptrDec  = (ptr == '0) ? PW'(DEPTH - 1) : ptr - PW'(1);
    assign topData = mem[ptrDec];
    assign popOk   = pop && (cnt != '0);
    assign count   = cnt;
    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            ptr <= '0;
            cnt <= '0;
        end else if (push && popOk) begin
            // Pop supplies the target; the pushed value reuses the freed top slot.
            mem[ptrDec] <= pushData;
        end else if (push) begin
            mem[ptr] <= pushData;
            ptr      <= ptrInc;
            cnt      <= full ? cnt : cnt + CW'(1);
        end else if (popOk) begin
            ptr <= ptrDec;
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/pc_generator.sv
// pc_generator: fetch PC register with prioritised next-PC selection and a return-address stack.
//
// Parameters
//   WIDTH      address width in bits
//   RESET_PC   fetch address after reset
//   INC        sequential increment in bytes
//   RAS_DEPTH  return-address stack entries (>= 2)
// Ports
//   clk   clock, rising edge
//   rst   asynchronous active-high reset
//   bus   pc_generator_if slave: redirect/stall/call/ret requests in,
//         fetch PC, PC+INC, PC source and RAS status out
module pc_generator
    import pc_gen_pkg::*;
#(
    parameter  int               WIDTH     = 32,
    parameter  logic [WIDTH-1:0] RESET_PC  = WIDTH'(32'h4),
    parameter  int               INC       = 4,
    parameter  int               RAS_DEPTH = 4,
    localparam int               CW        = rasCountWidth(RAS_DEPTH)
) (
    input logic           clk,
    input logic           rst,
    pc_generator_if.slave bus
);

    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pcPlus;
    logic [WIDTH-1:0] nextPc;
    logic [WIDTH-1:0] rasTop;
    pcSrc_t           src;
    pcSrc_t           nextSrc;
    logic [CW-1:0]    rasCount;
    logic             rasEmpty;
    logic             rasFull;
    logic             accept;
    logic             retHit;
    logic             rasPush;
    logic             rasFlush;

    assign pcPlus = pc + WIDTH'(INC);

    // A call/ret only takes effect when no redirect squashes the instruction
    // and the hazard unit is not holding fetch.
    assign accept   = !bus.i_PcGen_exc_valid && !bus.i_PcGen_br_valid && !bus.i_PcGen_stall;
    assign retHit   = accept && bus.i_PcGen_ret && !rasEmpty;
    assign rasPush  = accept && bus.i_PcGen_call;
    assign rasFlush = bus.i_PcGen_exc_valid || bus.i_PcGen_flush_ras;

    // retHit uses the pre-flush top, so a ret paired with flush still
    // predicts from the old stack contents.
    always_comb begin
        nextPc  = bus.i_PcGen_exc_valid ? bus.i_PcGen_exc_pc :
                  bus.i_PcGen_br_valid  ? bus.i_PcGen_br_pc  :
                  bus.i_PcGen_stall     ? pc                 :
                  retHit                ? rasTop             : pcPlus;
        nextSrc = bus.i_PcGen_exc_valid ? PC_SRC_EXC :
                  bus.i_PcGen_br_valid  ? PC_SRC_BR  :
                  bus.i_PcGen_stall     ? src        :
                  retHit                ? PC_SRC_RET : PC_SRC_SEQ;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc  <= RESET_PC;
            src <= PC_SRC_SEQ;
        end else begin
            pc  <= nextPc;
            src <= nextSrc;
        end
    end

    pc_ras #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) uRas (
        .clk      (clk),
        .rst      (rst),
        .push     (rasPush),
        .pop      (retHit),
        .flush    (rasFlush),
        .pushData (pcPlus),
        .topData  (rasTop),
        .count    (rasCount),
        .empty    (rasEmpty),
        .full     (rasFull)
    );

    assign bus.o_PcGen_pc        = pc;
    assign bus.o_PcGen_pc_plus   = pcPlus;
    assign bus.o_PcGen_src       = src;
    assign bus.o_PcGen_ras_count = rasCount;
    assign bus.o_PcGen_ras_empty = rasEmpty;
    assign bus.o_PcGen_ras_full  = rasFull;

endmodule

// File: doc/pc_generator.md
# pc_generator

Parametrised fetch-address generator for the instruction-fetch stage. It holds the current fetch PC and selects the next PC from four sources: sequential increment, resolved branch/jump redirect, exception vector, or a prediction popped from an internal return-address stack (RAS). Unlike the single-source counter it replaces, redirects from the back end override a fetch stall, and call/return pairs are predicted in the front end. It sits between the hazard unit and the instruction memory address port.

## Interface
- WIDTH, 32, address width in bits
- RESET_PC, 32'h4, fetch address after reset (WIDTH bits)
- INC, 4, sequential increment in bytes
- RAS_DEPTH, 4, return-address stack entries (≥2)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_PcGen_stall  in  1  hold fetch PC (hazard unit)
- i_PcGen_exc_valid  in  1  exception redirect request
- i_PcGen_exc_pc  in  WIDTH  exception target
- i_PcGen_br_valid  in  1  resolved branch/jump redirect request
- i_PcGen_br_pc  in  WIDTH  branch target
- i_PcGen_call  in  1  instruction at current PC is a call
- i_PcGen_ret  in  1  instruction at current PC is a return
- i_PcGen_flush_ras  in  1  clear RAS
- o_PcGen_pc  out  WIDTH  current fetch PC (registered)
- o_PcGen_pc_plus  out  WIDTH  o_PcGen_pc + INC (combinational)
- o_PcGen_src  out  2  source of current PC: 0 seq, 1 branch, 2 ret, 3 exc (registered)
- o_PcGen_ras_count  out  $clog2(RAS_DEPTH+1)  valid RAS entries
- o_PcGen_ras_empty  out  1  count == 0
- o_PcGen_ras_full  out  1  count == RAS_DEPTH

## Operation
- Next-PC priority: exc > branch > stall > ret (RAS non-empty) > sequential.
- exc_valid: PC ← exc_pc, src=3, RAS flushed; overrides stall.
- br_valid (no exc): PC ← br_pc, src=1; overrides stall; RAS untouched; call/ret ignored (instruction squashed).
- stall (no redirect): PC, src, RAS all hold; call/ret ignored.
- ret with RAS non-empty: PC ← top entry, src=2, pop.
- ret with RAS empty: treated as sequential, src=0, no pop.
- otherwise: PC ← pc_plus, src=0.
- call (accepted, i.e. no exc/br/stall): push pc_plus. Push when full overwrites oldest entry (circular buffer); count saturates at RAS_DEPTH.
- call and ret same accepted cycle: pop supplies target, then pc_plus written into freed top slot; count unchanged.
- flush_ras: count ← 0, pointer ← 0; wins over same-cycle call/ret push/pop, but a ret still reads the pre-flush top as target if count was non-zero.
- Arithmetic modulo 2^WIDTH; pc_plus wraps silently. No alignment checking.

## Timing
- Reset (async, immediate): o_PcGen_pc=RESET_PC, o_PcGen_src=0, count=0, empty=1, full=0, RAS entries 0, pointer 0.
- Reset released mid-operation: all state restarts from reset values; no pending redirect survives.
- All state updates on rising clk; next PC visible one cycle after request. RAS top read combinationally, so ret target appears in o_PcGen_pc the cycle after ret is asserted.
- Flag/count outputs registered, consistent with RAS contents in the same cycle.
- o_PcGen_pc_plus tracks o_PcGen_pc combinationally, zero latency.

## Structure
- Package pc_gen_pkg: source encodings PC_SRC_SEQ/BR/RET/EXC (2-bit) and width helper for RAS count.
- Sub-module pc_ras: circular LIFO with push, pop, push+pop, flush, count, empty/full; pc_generator holds PC register, priority mux and accept logic.

## Test plan
- Reset, then 3 free-run cycles -> PC 0x4, 0x8, 0xC, 0x10; src=0; ras_empty=1.
- stall=1 and br_valid=1 with br_pc=0x100 in same cycle -> next PC 0x100, src=1; stall alone for 2 cycles -> PC holds.
- At PC 0x20 call=1, at PC 0x40 ret=1 -> PC after ret = 0x24, src=2, count 1→0; ret when empty -> PC 0x44, src=0.
- RAS_DEPTH=4: 5 calls at 0x10,0x20,0x30,0x40,0x50 -> full=1, count=4; 4 rets yield 0x54,0x44,0x34,0x24, then empty=1.
- call+ret same cycle at PC 0x80 with top 0x24 -> next PC 0x24, top becomes 0x84, count unchanged.
- exc_valid with exc_pc=0x1000 while RAS holds 2 entries and stall=1 -> PC 0x1000, src=3, count=0; assert rst mid-stream -> PC 0x4 immediately, before next edge.
